// File: rtl/lut_gate_seq_if.sv
// Serial truth-table configuration channel for lut_gate_seq.
// The master offers bits (valid/bit/abort); the slave reports ready and parity errors.
interface lut_gate_seq_if;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_abort;
  logic cfg_ready;
  logic cfg_err;

  modport master (
    output cfg_valid,
    output cfg_bit,
    output cfg_abort,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_bit,
    input  cfg_abort,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/lut_gate_seq.sv
// Runtime-reprogrammable N-input truth-table gate with a settle filter on its output.
// Optional LUT_SEQ_PARITY_EN appends an even-parity bit to each serial table load.
module lut_gate_seq #(
  parameter int unsigned              N_IN       = 3,
  parameter int unsigned              SETTLE     = 4,
  parameter logic [(1<<N_IN)-1:0]     INIT_TABLE = 8'hF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  lut_gate_seq_if.slave    cfg,
  output logic             out,
  output logic             settled,
  output logic             busy
);

  localparam int unsigned TW  = 1 << N_IN;
  localparam int unsigned CW  = $clog2(SETTLE) + 1;
`ifdef LUT_SEQ_PARITY_EN
  localparam int unsigned L   = TW + 1;
`else
  localparam int unsigned L   = TW;
`endif
  localparam int unsigned BCW = $clog2(L + 1);

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    COMMIT
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   table_q, table_d;
  logic [N_IN-1:0] in_q, in_d;
  logic [N_IN-1:0] idx;
  logic            raw_q, raw_d;
  logic            out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [L-1:0]    shadow_q, shadow_d;
  logic [BCW-1:0]  bitcnt_q, bitcnt_d;
  logic            accept;
  logic            parity_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      table_q  <= INIT_TABLE;
      in_q     <= '0;
      raw_q    <= INIT_TABLE[TW-1];
      out_q    <= INIT_TABLE[TW-1];
      cnt_q    <= '0;
      shadow_q <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      table_q  <= table_d;
      in_q     <= in_d;
      raw_q    <= raw_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Table bit TW-1-k holds the output for input k, and TW-1-k == ~k in N_IN bits.
  always_comb begin
    in_d  = in;
    idx   = ~in_q;
    raw_d = table_q[idx];
  end

  // Settle filter: out only follows raw after SETTLE consecutive disagreeing cycles.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (raw_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(SETTLE - 1)) begin
      out_d = raw_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
`ifdef LUT_SEQ_PARITY_EN
    parity_ok = ~^shadow_q;
`else
    parity_ok = 1'b1;
`endif
  end

  // Next-state process for the configuration FSM and its shadow/bit counter.
  always_comb begin
    state_d  = state_q;
    table_d  = table_q;
    shadow_d = shadow_q;
    bitcnt_d = bitcnt_q;
    accept   = cfg.cfg_valid && cfg.cfg_ready;
    case (state_q)
      RUN: begin
        if (cfg.cfg_abort) begin
          shadow_d = '0;
          bitcnt_d = '0;
        end else if (accept) begin
          shadow_d = {shadow_q[L-2:0], cfg.cfg_bit};
          bitcnt_d = BCW'(1);
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (cfg.cfg_abort) begin
          shadow_d = '0;
          bitcnt_d = '0;
          state_d  = RUN;
        end else if (accept) begin
          shadow_d = {shadow_q[L-2:0], cfg.cfg_bit};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BCW'(L - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (parity_ok) begin
          table_d = shadow_q[L-1 -: TW];
        end
        shadow_d = '0;
        bitcnt_d = '0;
        state_d  = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output process: ready/busy/err decode purely from state and abort.
  always_comb begin
    cfg.cfg_ready = (state_q != COMMIT) && !cfg.cfg_abort;
    cfg.cfg_err   = 1'b0;
`ifdef LUT_SEQ_PARITY_EN
    cfg.cfg_err   = (state_q == COMMIT) && !parity_ok;
`endif
    busy          = (state_q == LOAD) || (state_q == COMMIT);
    out           = out_q;
    settled       = (raw_q == out_q);
  end

endmodule

// File: tb/tb_lut_gate_seq.sv
// Scoreboard bench for lut_gate_seq: driver pushes expected outputs from a queue-based model,
// a negedge monitor pops and compares them.
module tb_lut_gate_seq;

  localparam int N_IN   = 3;
  localparam int SETTLE = 4;
  localparam int TW     = 8;
`ifdef LUT_SEQ_PARITY_EN
  localparam int L = TW + 1;
`else
  localparam int L = TW;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tin;
  logic       dout, dsettled, dbusy;

  lut_gate_seq_if cfg();

  lut_gate_seq #(
    .N_IN      (N_IN),
    .SETTLE    (SETTLE),
    .INIT_TABLE(8'hF0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (tin),
    .cfg    (cfg),
    .out    (dout),
    .settled(dsettled),
    .busy   (dbusy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic out_v;
    logic settled_v;
    logic ready_v;
    logic busy_v;
    logic err_v;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: table as an integer, received config bits as a queue.
  int m_table;
  int m_in;
  bit m_raw, m_out;
  int m_disagree;
  bit m_bits[$];
  bit m_commit;
  int cur_in;

  function automatic void model_reset();
    m_table    = 8'hF0;
    m_in       = 0;
    m_raw      = 1'b1;
    m_out      = 1'b1;
    m_disagree = 0;
    m_bits.delete();
    m_commit   = 1'b0;
  endfunction

  function automatic bit parity_bad();
    bit x = 1'b0;
`ifdef LUT_SEQ_PARITY_EN
    foreach (m_bits[k]) x ^= m_bits[k];
`endif
    return x;
  endfunction

  function automatic int table_of_bits();
    int t = 0;
    for (int k = 0; k < TW; k++) t = (t << 1) | int'(m_bits[k]);
    return t;
  endfunction

  function automatic void model_edge(int i, bit v, bit b, bit a, bit r);
    bit new_raw;
    if (r) begin
      model_reset();
      return;
    end
    new_raw = bit'((m_table >> (TW - 1 - m_in)) & 1);
    if (m_raw != m_out) begin
      m_disagree++;
      if (m_disagree == SETTLE) begin
        m_out      = m_raw;
        m_disagree = 0;
      end
    end else begin
      m_disagree = 0;
    end
    m_raw = new_raw;
    m_in  = i;
    if (m_commit) begin
      if (!parity_bad()) m_table = table_of_bits();
      m_bits.delete();
      m_commit = 1'b0;
    end else if (a) begin
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() == L) m_commit = 1'b1;
    end
  endfunction

  task automatic drive(int i, bit v, bit b, bit a, bit r);
    obs_t e;
    tin           = 3'(i);
    cfg.cfg_valid = v;
    cfg.cfg_bit   = b;
    cfg.cfg_abort = a;
    rst           = r;
    e.out_v     = m_out;
    e.settled_v = (m_raw == m_out);
    e.ready_v   = !m_commit && !a;
    e.busy_v    = m_commit || (m_bits.size() != 0);
    e.err_v     = m_commit && parity_bad();
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(i, v, b, a, r);
    #1;
  endtask

  task automatic hold(int i, int n);
    cur_in = i;
    for (int k = 0; k < n; k++) drive(cur_in, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(int value, int nbits, bit parity);
    for (int k = 0; k < nbits; k++) begin
      bit b;
      b = (k < TW) ? bit'((value >> (TW - 1 - k)) & 1) : parity;
      drive(cur_in, 1'b1, b, 1'b0, 1'b0);
    end
  endtask

  task automatic load(int value, bit parity);
    send_bits(value, L, parity);
    drive(cur_in, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    obs_t e, act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = '{dout, dsettled, cfg.cfg_ready, dbusy, cfg.cfg_err};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL obs_check t=%0t out/settled/ready/busy/err got=%b required=%b",
                   $time, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    rst           = 1'b1;
    tin           = '0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_bit   = 1'b0;
    cfg.cfg_abort = 1'b0;
    cur_in        = 0;
    @(posedge clk);
    model_reset();
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state, then input 4 makes out fall after the pipeline plus settle delay.
    hold(0, 3);
    hold(4, 8);
    hold(0, 8);
    // Short glitch toward 0 must be suppressed.
    hold(5, 3);
    hold(0, 8);
    // Load 0x01 and exercise both ends of the new table.
    load(8'h01, 1'b1);
    hold(7, 8);
    hold(0, 8);
    // Abort after five bits with a bit offered in the same cycle, then load 0x0F.
    send_bits(8'h0F, 5, 1'b0);
    drive(cur_in, 1'b1, 1'b1, 1'b1, 1'b0);
    hold(0, 2);
    load(8'h0F, 1'b0);
    hold(7, 8);
    hold(0, 8);
    // Reset mid-load restores the initial table.
    send_bits(8'h01, 4, 1'b1);
    drive(cur_in, 1'b0, 1'b0, 1'b0, 1'b1);
    hold(0, 8);
    hold(4, 8);
    hold(0, 8);
`ifdef LUT_SEQ_PARITY_EN
    load(8'h3C, 1'b0);
    hold(2, 8);
    load(8'h3D, 1'b0);
    hold(7, 8);
    hold(0, 8);
`endif
    // Back-to-back loads.
    load(8'hA5, 1'b0);
    load(8'h5A, 1'b0);
    hold(1, 8);

    for (int n = 0; n < 3000; n++) begin
      bit v, b, a, r;
      if ($urandom_range(0, 5) == 0) cur_in = int'($urandom_range(0, 7));
      v = ($urandom_range(0, 2) == 0);
      b = bit'($urandom_range(0, 1));
      a = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 499) == 0);
      drive(cur_in, v, b, a, r);
    end
    hold(0, 4);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
